// File: rtl/imem_boot_loader.sv
// Byte-stream boot loader: parses a framed program image, writes it into instr_mem
// word by word, and releases the core from reset only after the checksum verifies.
module imem_boot_loader #(
    parameter int          ADDR_WIDTH = 8,
    parameter logic [7:0]  MAGIC      = 8'hA5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    input  logic                  restart,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  core_reset,
    output logic                  boot_done,
    output logic                  boot_error
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERROR
    } state_e;

    localparam longint unsigned CAPACITY = 64'd1 << ADDR_WIDTH;

    state_e                  state_q;
    logic [15:0]             len_q;
    logic [15:0]             word_cnt_q;
    logic [1:0]              byte_cnt_q;
    logic [23:0]             word_q;
    logic [7:0]              xor_q;
    logic                    imem_we_q;
    logic [ADDR_WIDTH-1:0]   imem_addr_q;
    logic [31:0]             imem_wdata_q;
    logic                    core_reset_q;
    logic                    boot_done_q;
    logic                    boot_error_q;

    logic                    xfer;
    logic [15:0]             len_d;
    logic [31:0]             word_d;
    logic [7:0]              xor_d;
    logic                    last_word;

    assign in_ready  = (state_q != S_DONE) && (state_q != S_ERROR);
    assign xfer      = in_valid && in_ready;
    assign len_d     = {in_data, len_q[7:0]};
    assign word_d    = {in_data, word_q};
    assign xor_d     = xor_q ^ in_data;
    assign last_word = (word_cnt_q == len_q - 16'd1);

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            word_cnt_q   <= '0;
            byte_cnt_q   <= '0;
            word_q       <= '0;
            xor_q        <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            core_reset_q <= 1'b1;
            boot_done_q  <= 1'b0;
            boot_error_q <= 1'b0;
        end else begin
            imem_we_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // Anything other than MAGIC is line noise ahead of a frame.
                    if (xfer && in_data == MAGIC) begin
                        state_q    <= S_LEN0;
                        word_cnt_q <= '0;
                        byte_cnt_q <= '0;
                        xor_q      <= '0;
                    end
                end
                S_LEN0: begin
                    if (xfer) begin
                        len_q   <= {8'h00, in_data};
                        state_q <= S_LEN1;
                    end
                end
                S_LEN1: begin
                    if (xfer) begin
                        len_q <= len_d;
                        if (64'(len_d) > CAPACITY) begin
                            state_q      <= S_ERROR;
                            boot_error_q <= 1'b1;
                        end else if (len_d == 16'd0) begin
                            state_q <= S_CSUM;
                        end else begin
                            state_q <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        xor_q      <= xor_d;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        case (byte_cnt_q)
                            2'd0: word_q[7:0]   <= in_data;
                            2'd1: word_q[15:8]  <= in_data;
                            2'd2: word_q[23:16] <= in_data;
                            default: begin
                                imem_we_q    <= 1'b1;
                                imem_addr_q  <= word_cnt_q[ADDR_WIDTH-1:0];
                                imem_wdata_q <= word_d;
                                word_cnt_q   <= word_cnt_q + 16'd1;
                                if (last_word) state_q <= S_CSUM;
                            end
                        endcase
                    end
                end
                S_CSUM: begin
                    if (xfer) begin
                        if (in_data == xor_q) begin
                            state_q      <= S_DONE;
                            boot_done_q  <= 1'b1;
                            core_reset_q <= 1'b0;
                        end else begin
                            state_q      <= S_ERROR;
                            boot_error_q <= 1'b1;
                        end
                    end
                end
                S_DONE, S_ERROR: begin
                    if (restart) begin
                        state_q      <= S_IDLE;
                        core_reset_q <= 1'b1;
                        boot_done_q  <= 1'b0;
                        boot_error_q <= 1'b0;
                        len_q        <= '0;
                        word_cnt_q   <= '0;
                        byte_cnt_q   <= '0;
                        word_q       <= '0;
                        xor_q        <= '0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign core_reset = core_reset_q;
    assign boot_done  = boot_done_q;
    assign boot_error = boot_error_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: frames are built in the bench, expected
// instr_mem writes go to a scoreboard queue and are matched as the DUT strobes them.
module tb_imem_boot_loader;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        restart = 1'b0;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        core_reset;
    logic        boot_done;
    logic        boot_error;

    int errors = 0;
    int checks = 0;
    int write_cnt = 0;

    wr_t         exp_q[$];
    logic [31:0] words[$];
    logic [7:0]  tx[$];

    imem_boot_loader #(.ADDR_WIDTH(8), .MAGIC(8'hA5)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .restart    (restart),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_reset (core_reset),
        .boot_done  (boot_done),
        .boot_error (boot_error)
    );

    always #5 clk = ~clk;

    // Each write strobe must match the oldest expected write and precede boot_done.
    always @(negedge clk) begin
        if (imem_we) begin
            wr_t e;
            write_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected: got addr=%h data=%h, required no write", imem_addr, imem_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({imem_addr, imem_wdata, boot_done} !== {e.addr, e.data, 1'b0}) begin
                    errors++;
                    $display("FAIL write: got addr=%h data=%h done=%b, required addr=%h data=%h done=0",
                             imem_addr, imem_wdata, boot_done, e.addr, e.data);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic build_frame(input bit corrupt, input bit expect_writes);
        logic [7:0]  x = 8'h00;
        logic [15:0] n = 16'(words.size());
        logic [31:0] w;
        tx.delete();
        tx.push_back(8'hA5);
        tx.push_back(n[7:0]);
        tx.push_back(n[15:8]);
        for (int i = 0; i < words.size(); i++) begin
            w = words[i];
            for (int b = 0; b < 4; b++) begin
                tx.push_back(w[8*b +: 8]);
                x = x ^ w[8*b +: 8];
            end
            if (expect_writes) exp_q.push_back('{addr: 8'(i), data: w});
        end
        tx.push_back(x ^ {7'd0, corrupt});
    endtask

    task automatic load_test2_words();
        words.delete();
        words.push_back(32'h00500093);
        words.push_back(32'h00A00113);
    endtask

    task automatic send_stream(input int max_gap, input bit poke_restart);
        logic [7:0] b;
        int gap;
        while (tx.size() > 0) begin
            b = tx.pop_front();
            gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            repeat (gap) begin
                if (poke_restart && $urandom_range(0, 3) == 0) restart = 1'b1;
                @(posedge clk); #1;
                restart = 1'b0;
            end
            in_valid = 1'b1;
            in_data  = b;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL in_ready_stream: got %b, required 1 while sending %h", in_ready, b);
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_flags(input int budget, input string name);
        int n = 0;
        while (!(boot_done === 1'b1 || boot_error === 1'b1) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (!(boot_done === 1'b1 || boot_error === 1'b1)) begin
            errors++;
            $display("FAIL %s_timeout: got done=%b error=%b after %0d cycles, required a flag", name, boot_done, boot_error, budget);
        end
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(posedge clk); #1;
        restart = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({core_reset, imem_we, boot_done, boot_error} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_flags: got core_reset,we,done,error=%b, required 1000", {core_reset, imem_we, boot_done, boot_error});
        end
        checks++;
        if ({imem_addr, imem_wdata} !== 40'h0) begin
            errors++;
            $display("FAIL reset_bus: got addr=%h data=%h, required 0", imem_addr, imem_wdata);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({in_ready, core_reset, boot_done, boot_error} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_release: got ready,core_reset,done,error=%b, required 1100", {in_ready, core_reset, boot_done, boot_error});
        end
    endtask

    task automatic test_good_frame();
        int w0 = write_cnt;
        load_test2_words();
        build_frame(1'b0, 1'b1);
        send_stream(0, 1'b0);
        wait_flags(8, "good");
        checks++;
        if ({boot_done, boot_error, core_reset, in_ready} !== 4'b1000) begin
            errors++;
            $display("FAIL good_result: got done,error,core_reset,ready=%b, required 1000", {boot_done, boot_error, core_reset, in_ready});
        end
        checks++;
        if (write_cnt - w0 != 2 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL good_writes: got %0d writes, %0d pending, required 2 and 0", write_cnt - w0, exp_q.size());
        end
        pulse_restart();
        checks++;
        if ({boot_done, core_reset, in_ready} !== 3'b011) begin
            errors++;
            $display("FAIL good_restart: got done,core_reset,ready=%b, required 011", {boot_done, core_reset, in_ready});
        end
    endtask

    task automatic test_bad_csum();
        int w0 = write_cnt;
        load_test2_words();
        build_frame(1'b1, 1'b1);
        send_stream(0, 1'b0);
        wait_flags(8, "badcsum");
        checks++;
        if ({boot_error, boot_done, core_reset, in_ready} !== 4'b1010) begin
            errors++;
            $display("FAIL badcsum_result: got error,done,core_reset,ready=%b, required 1010", {boot_error, boot_done, core_reset, in_ready});
        end
        checks++;
        if (write_cnt - w0 != 2 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL badcsum_writes: got %0d writes, %0d pending, required 2 and 0", write_cnt - w0, exp_q.size());
        end
        pulse_restart();
        checks++;
        if ({boot_error, core_reset, in_ready} !== 3'b011) begin
            errors++;
            $display("FAIL badcsum_restart: got error,core_reset,ready=%b, required 011", {boot_error, core_reset, in_ready});
        end
    endtask

    task automatic test_junk_gaps();
        int w0 = write_cnt;
        tx.delete();
        tx.push_back(8'h00);
        tx.push_back(8'hFF);
        tx.push_back(8'h5A);
        send_stream(2, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({boot_done, boot_error, in_ready} !== 3'b001 || write_cnt != w0) begin
            errors++;
            $display("FAIL junk_ignored: got done,error,ready=%b writes=%0d, required 001 and 0", {boot_done, boot_error, in_ready}, write_cnt - w0);
        end
        load_test2_words();
        build_frame(1'b0, 1'b1);
        send_stream(3, 1'b1);
        wait_flags(8, "gaps");
        checks++;
        if ({boot_done, boot_error, core_reset} !== 3'b100 || write_cnt - w0 != 2 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL gaps_result: got done,error,core_reset=%b writes=%0d, required 100 and 2", {boot_done, boot_error, core_reset}, write_cnt - w0);
        end
        pulse_restart();
    endtask

    task automatic test_length_bounds();
        int w0 = write_cnt;
        tx.delete();
        tx.push_back(8'hA5);
        tx.push_back(8'h01);
        tx.push_back(8'h01);
        send_stream(0, 1'b0);
        wait_flags(2, "oversize");
        checks++;
        if ({boot_error, boot_done, core_reset, in_ready} !== 4'b1010 || write_cnt != w0) begin
            errors++;
            $display("FAIL oversize: got error,done,core_reset,ready=%b writes=%0d, required 1010 and 0", {boot_error, boot_done, core_reset, in_ready}, write_cnt - w0);
        end
        pulse_restart();

        words.delete();
        build_frame(1'b0, 1'b1);
        send_stream(0, 1'b0);
        wait_flags(4, "empty");
        checks++;
        if ({boot_done, boot_error, core_reset} !== 3'b100 || write_cnt != w0) begin
            errors++;
            $display("FAIL empty: got done,error,core_reset=%b writes=%0d, required 100 and 0", {boot_done, boot_error, core_reset}, write_cnt - w0);
        end
        pulse_restart();

        words.delete();
        for (int i = 0; i < 256; i++) words.push_back($urandom());
        build_frame(1'b0, 1'b1);
        send_stream(0, 1'b0);
        wait_flags(8, "full");
        checks++;
        if ({boot_done, boot_error} !== 2'b10 || write_cnt - w0 != 256 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL full_capacity: got done,error=%b writes=%0d, required 10 and 256", {boot_done, boot_error}, write_cnt - w0);
        end
        pulse_restart();
    endtask

    task automatic test_reset_mid_frame();
        int w0 = write_cnt;
        load_test2_words();
        build_frame(1'b0, 1'b0);
        exp_q.push_back('{addr: 8'd0, data: 32'h00500093});
        while (tx.size() > 9) void'(tx.pop_back());
        send_stream(0, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({core_reset, imem_we, boot_done, boot_error, in_ready} !== 5'b10001) begin
            errors++;
            $display("FAIL midreset_flags: got core_reset,we,done,error,ready=%b, required 10001", {core_reset, imem_we, boot_done, boot_error, in_ready});
        end
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (write_cnt - w0 != 1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL midreset_writes: got %0d writes, %0d pending, required 1 and 0", write_cnt - w0, exp_q.size());
        end
        build_frame(1'b0, 1'b1);
        send_stream(1, 1'b0);
        wait_flags(8, "resend");
        checks++;
        if ({boot_done, boot_error, core_reset} !== 3'b100 || write_cnt - w0 != 3 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL resend_result: got done,error,core_reset=%b writes=%0d, required 100 and 3", {boot_done, boot_error, core_reset}, write_cnt - w0);
        end
        pulse_restart();
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_csum();
        test_junk_gaps();
        test_length_bounds();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
